// File: rtl/skin_pkg.sv
`default_nettype none
// skin_pkg -- shared widths, mask levels and the inclusive window compare for skin_detect.
// Rev 1.0
package skin_pkg;

  localparam int DEF_XW   = 11;
  localparam int DEF_YW   = 11;
  localparam int DEF_CNTW = 21;

  localparam logic [7:0] SKIN_ON  = 8'hFF;
  localparam logic [7:0] SKIN_OFF = 8'h00;

  // A wrapped window accepts everything outside the open gap (hi, lo).
  function automatic logic in_window(input logic [7:0] val, input logic [7:0] lo,
                                     input logic [7:0] hi, input logic wrap);
    if (wrap) return (val >= lo) || (val <= hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skin_bbox_accum.sv
`default_nettype none
// skin_bbox_accum -- per-frame skin pixel count and bounding box, published and cleared at frame end.
// Rev 1.0
module skin_bbox_accum
  import skin_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            clear,
  input  logic            publish,
  input  logic            pix_valid,
  input  logic [XW-1:0]   pix_x,
  input  logic [YW-1:0]   pix_y,
  output logic [CNTW-1:0] skin_count,
  output logic [XW-1:0]   x_min,
  output logic [XW-1:0]   x_max,
  output logic [YW-1:0]   y_min,
  output logic [YW-1:0]   y_max,
  output logic            bbox_found,
  output logic            stats_valid
);

  logic [CNTW-1:0] cnt_q, cnt_d, cnt_out_q, cnt_out_d;
  logic [XW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, xmin_out_q, xmin_out_d, xmax_out_q, xmax_out_d;
  logic [YW-1:0]   ymin_q, ymin_d, ymax_q, ymax_d, ymin_out_q, ymin_out_d, ymax_out_q, ymax_out_d;
  logic            found_q, found_d, found_out_q, found_out_d, valid_q, valid_d;

  always_comb begin
    cnt_d       = cnt_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    found_d     = found_q;
    cnt_out_d   = cnt_out_q;
    xmin_out_d  = xmin_out_q;
    xmax_out_d  = xmax_out_q;
    ymin_out_d  = ymin_out_q;
    ymax_out_d  = ymax_out_q;
    found_out_d = found_out_q;
    valid_d     = 1'b0;
    if (ce) begin
      if (publish) begin
        cnt_out_d   = cnt_q;
        xmin_out_d  = xmin_q;
        xmax_out_d  = xmax_q;
        ymin_out_d  = ymin_q;
        ymax_out_d  = ymax_q;
        found_out_d = found_q;
        valid_d     = 1'b1;
      end
      if (clear) begin
        cnt_d   = '0;
        xmin_d  = '0;
        xmax_d  = '0;
        ymin_d  = '0;
        ymax_d  = '0;
        found_d = 1'b0;
      end
      // Evaluated after the clear so a pixel coinciding with frame end opens the new frame.
      if (pix_valid) begin
        if (!found_d) begin
          cnt_d   = CNTW'(1);
          xmin_d  = pix_x;
          xmax_d  = pix_x;
          ymin_d  = pix_y;
          ymax_d  = pix_y;
          found_d = 1'b1;
        end else begin
          if (cnt_d != '1) cnt_d = cnt_d + CNTW'(1);
          if (pix_x < xmin_d) xmin_d = pix_x;
          if (pix_x > xmax_d) xmax_d = pix_x;
          if (pix_y < ymin_d) ymin_d = pix_y;
          if (pix_y > ymax_d) ymax_d = pix_y;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      found_q     <= 1'b0;
      cnt_out_q   <= '0;
      xmin_out_q  <= '0;
      xmax_out_q  <= '0;
      ymin_out_q  <= '0;
      ymax_out_q  <= '0;
      found_out_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      found_q     <= found_d;
      cnt_out_q   <= cnt_out_d;
      xmin_out_q  <= xmin_out_d;
      xmax_out_q  <= xmax_out_d;
      ymin_out_q  <= ymin_out_d;
      ymax_out_q  <= ymax_out_d;
      found_out_q <= found_out_d;
      valid_q     <= valid_d;
    end
  end

  assign skin_count  = cnt_out_q;
  assign x_min       = xmin_out_q;
  assign x_max       = xmax_out_q;
  assign y_min       = ymin_out_q;
  assign y_max       = ymax_out_q;
  assign bbox_found  = found_out_q;
  assign stats_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/skin_detect.sv
`default_nettype none
// skin_detect -- HSV window skin classifier producing a 2-cycle binary mask stream plus per-frame stats.
// Rev 1.0
module skin_detect
  import skin_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            de_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic [7:0]      H,
  input  logic [7:0]      S,
  input  logic [7:0]      V,
  input  logic [7:0]      h_min,
  input  logic [7:0]      h_max,
  input  logic [7:0]      s_min,
  input  logic [7:0]      s_max,
  input  logic [7:0]      v_min,
  input  logic [7:0]      v_max,
  output logic [7:0]      mask_r,
  output logic [7:0]      mask_g,
  output logic [7:0]      mask_b,
  output logic            de_out,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic [CNTW-1:0] skin_count,
  output logic [XW-1:0]   x_min,
  output logic [XW-1:0]   x_max,
  output logic [YW-1:0]   y_min,
  output logic [YW-1:0]   y_max,
  output logic            bbox_found,
  output logic            stats_valid
);

  logic          vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d, x_s1_q, x_s1_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d, y_s1_q, y_s1_d;
  logic [7:0]    hmin_q, hmin_d, hmax_q, hmax_d, smin_q, smin_d;
  logic [7:0]    smax_q, smax_d, vmin_q, vmin_d, vmax_q, vmax_d;
  logic          hue_ok_q, hue_ok_d, sat_ok_q, sat_ok_d, val_ok_q, val_ok_d;
  logic          de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, vsr_s1_q, vsr_s1_d;
  logic          de_s2_q, de_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic [7:0]    mask_q, mask_d;
  logic          vs_rise, de_fall, skin;

  always_comb begin
    vs_rise  = vsync_in & ~vs_prev_q;
    de_fall  = ~de_in & de_prev_q;
    skin     = de_s1_q & hue_ok_q & sat_ok_q & val_ok_q;
    vs_prev_d = vs_prev_q;
    de_prev_d = de_prev_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    hmin_d   = hmin_q;
    hmax_d   = hmax_q;
    smin_d   = smin_q;
    smax_d   = smax_q;
    vmin_d   = vmin_q;
    vmax_d   = vmax_q;
    hue_ok_d = hue_ok_q;
    sat_ok_d = sat_ok_q;
    val_ok_d = val_ok_q;
    de_s1_d  = de_s1_q;
    hs_s1_d  = hs_s1_q;
    vs_s1_d  = vs_s1_q;
    vsr_s1_d = vsr_s1_q;
    x_s1_d   = x_s1_q;
    y_s1_d   = y_s1_q;
    de_s2_d  = de_s2_q;
    hs_s2_d  = hs_s2_q;
    vs_s2_d  = vs_s2_q;
    mask_d   = mask_q;
    if (ce) begin
      vs_prev_d = vsync_in;
      de_prev_d = de_in;
      if (de_in) begin
        if (x_cnt_q != '1) x_cnt_d = x_cnt_q + XW'(1);
      end else if (de_fall) begin
        x_cnt_d = '0;
      end
      if (vs_rise) y_cnt_d = '0;
      else if (de_fall && (y_cnt_q != '1)) y_cnt_d = y_cnt_q + YW'(1);
      // Shadows change only at frame start; this cycle still compares against the old window.
      if (vs_rise) begin
        hmin_d = h_min;
        hmax_d = h_max;
        smin_d = s_min;
        smax_d = s_max;
        vmin_d = v_min;
        vmax_d = v_max;
      end
      hue_ok_d = in_window(H, hmin_q, hmax_q, hmin_q > hmax_q);
      sat_ok_d = in_window(S, smin_q, smax_q, 1'b0);
      val_ok_d = in_window(V, vmin_q, vmax_q, 1'b0);
      de_s1_d  = de_in;
      hs_s1_d  = hsync_in;
      vs_s1_d  = vsync_in;
      vsr_s1_d = vs_rise;
      x_s1_d   = x_cnt_q;
      y_s1_d   = y_cnt_q;
      de_s2_d  = de_s1_q;
      hs_s2_d  = hs_s1_q;
      vs_s2_d  = vs_s1_q;
      mask_d   = skin ? SKIN_ON : SKIN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      hmin_q    <= '0;
      hmax_q    <= '0;
      smin_q    <= '0;
      smax_q    <= '0;
      vmin_q    <= '0;
      vmax_q    <= '0;
      hue_ok_q  <= 1'b0;
      sat_ok_q  <= 1'b0;
      val_ok_q  <= 1'b0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      vsr_s1_q  <= 1'b0;
      x_s1_q    <= '0;
      y_s1_q    <= '0;
      de_s2_q   <= 1'b0;
      hs_s2_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      mask_q    <= '0;
    end else begin
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      hmin_q    <= hmin_d;
      hmax_q    <= hmax_d;
      smin_q    <= smin_d;
      smax_q    <= smax_d;
      vmin_q    <= vmin_d;
      vmax_q    <= vmax_d;
      hue_ok_q  <= hue_ok_d;
      sat_ok_q  <= sat_ok_d;
      val_ok_q  <= val_ok_d;
      de_s1_q   <= de_s1_d;
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      vsr_s1_q  <= vsr_s1_d;
      x_s1_q    <= x_s1_d;
      y_s1_q    <= y_s1_d;
      de_s2_q   <= de_s2_d;
      hs_s2_q   <= hs_s2_d;
      vs_s2_q   <= vs_s2_d;
      mask_q    <= mask_d;
    end
  end

  skin_bbox_accum #(
    .XW  (XW),
    .YW  (YW),
    .CNTW(CNTW)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .clear      (vsr_s1_q),
    .publish    (vsr_s1_q),
    .pix_valid  (skin),
    .pix_x      (x_s1_q),
    .pix_y      (y_s1_q),
    .skin_count (skin_count),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .bbox_found (bbox_found),
    .stats_valid(stats_valid)
  );

  assign mask_r    = mask_q;
  assign mask_g    = mask_q;
  assign mask_b    = mask_q;
  assign de_out    = de_s2_q;
  assign hsync_out = hs_s2_q;
  assign vsync_out = vs_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_skin_detect.sv
`default_nettype none
// tb_skin_detect -- directed stimulus with a scoreboard queue for mask, syncs and frame stats.
module tb_skin_detect;

  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0]  H = '0, S = '0, V = '0;
  logic [7:0]  h_min = '0, h_max = '0, s_min = '0, s_max = '0, v_min = '0, v_max = '0;
  logic [7:0]  mask_r, mask_g, mask_b;
  logic        de_out, hsync_out, vsync_out, bbox_found, stats_valid;
  logic [20:0] skin_count;
  logic [10:0] x_min, x_max, y_min, y_max;

  always #5 clk = ~clk;

  skin_detect #(.XW(11), .YW(11), .CNTW(21)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .H(H), .S(S), .V(V), .h_min(h_min), .h_max(h_max), .s_min(s_min), .s_max(s_max),
    .v_min(v_min), .v_max(v_max), .mask_r(mask_r), .mask_g(mask_g), .mask_b(mask_b),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .skin_count(skin_count),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .bbox_found(bbox_found), .stats_valid(stats_valid)
  );

  typedef struct {
    bit de, hs, vs, sv, found;
    bit [7:0] mask;
    int cnt, xmin, xmax, ymin, ymax;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int pulses = 0;
  int cap_cnt, cap_xmin, cap_xmax, cap_ymin, cap_ymax;
  bit cap_found;

  // Reference model of thresholds, coordinates and accumulator.
  bit [7:0] m_hmin, m_hmax, m_smin, m_smax, m_vmin, m_vmax;
  int m_x, m_y, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  bit m_found, m_vs_prev, m_de_prev;

  task automatic model_reset();
    m_hmin = 0; m_hmax = 0; m_smin = 0; m_smax = 0; m_vmin = 0; m_vmax = 0;
    m_x = 0; m_y = 0; m_cnt = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    m_found = 0; m_vs_prev = 0; m_de_prev = 0;
    q.delete();
  endtask

  function automatic bit win(input bit [7:0] v, input bit [7:0] lo, input bit [7:0] hi, input bit wrap);
    if (wrap) return (v >= lo) || (v <= hi);
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit de, input bit hs, input bit vs,
                      input bit [7:0] h, input bit [7:0] s, input bit [7:0] v);
    exp_t e;
    bit vr, df, sk;
    de_in = de; hsync_in = hs; vsync_in = vs; H = h; S = s; V = v;
    vr = vs && !m_vs_prev;
    df = !de && m_de_prev;
    sk = de && win(h, m_hmin, m_hmax, m_hmin > m_hmax) && win(s, m_smin, m_smax, 1'b0)
            && win(v, m_vmin, m_vmax, 1'b0);
    e.de = de; e.hs = hs; e.vs = vs; e.sv = vr;
    e.mask = sk ? 8'hFF : 8'h00;
    e.cnt = m_cnt; e.found = m_found;
    e.xmin = m_xmin; e.xmax = m_xmax; e.ymin = m_ymin; e.ymax = m_ymax;
    if (vr) begin
      m_cnt = 0; m_found = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    end
    if (sk) begin
      if (!m_found) begin
        m_found = 1; m_cnt = 1;
        m_xmin = m_x; m_xmax = m_x; m_ymin = m_y; m_ymax = m_y;
      end else begin
        m_cnt++;
        if (m_x < m_xmin) m_xmin = m_x;
        if (m_x > m_xmax) m_xmax = m_x;
        if (m_y < m_ymin) m_ymin = m_y;
        if (m_y > m_ymax) m_ymax = m_y;
      end
    end
    if (de) begin
      if (m_x != 2047) m_x++;
    end else if (df) m_x = 0;
    if (vr) m_y = 0;
    else if (df && m_y != 2047) m_y++;
    if (vr) begin
      m_hmin = h_min; m_hmax = h_max; m_smin = s_min; m_smax = s_max; m_vmin = v_min; m_vmax = v_max;
    end
    m_vs_prev = vs; m_de_prev = de;
    q.push_back(e);
    @(posedge clk); #1;
    if (stats_valid === 1'b1) begin
      pulses++;
      cap_cnt = int'(skin_count); cap_found = bbox_found;
      cap_xmin = int'(x_min); cap_xmax = int'(x_max); cap_ymin = int'(y_min); cap_ymax = int'(y_max);
    end
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("mask_r", 32'(mask_r), 32'(e.mask));
      chk("mask_g", 32'(mask_g), 32'(e.mask));
      chk("mask_b", 32'(mask_b), 32'(e.mask));
      chk("de_out", 32'(de_out), 32'(e.de));
      chk("hsync_out", 32'(hsync_out), 32'(e.hs));
      chk("vsync_out", 32'(vsync_out), 32'(e.vs));
      chk("stats_valid", 32'(stats_valid), 32'(e.sv));
      if (e.sv) begin
        chk("skin_count", 32'(skin_count), e.cnt);
        chk("bbox_found", 32'(bbox_found), 32'(e.found));
        chk("x_min", 32'(x_min), e.xmin);
        chk("x_max", 32'(x_max), e.xmax);
        chk("y_min", 32'(y_min), e.ymin);
        chk("y_max", 32'(y_max), e.ymax);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic vpulse();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    idle(3);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mask_r"}, 32'(mask_r), 0);
    chk({tag, "_mask_g"}, 32'(mask_g), 0);
    chk({tag, "_mask_b"}, 32'(mask_b), 0);
    chk({tag, "_de"}, 32'(de_out), 0);
    chk({tag, "_hs"}, 32'(hsync_out), 0);
    chk({tag, "_vs"}, 32'(vsync_out), 0);
    chk({tag, "_cnt"}, 32'(skin_count), 0);
    chk({tag, "_xmin"}, 32'(x_min), 0);
    chk({tag, "_xmax"}, 32'(x_max), 0);
    chk({tag, "_ymin"}, 32'(y_min), 0);
    chk({tag, "_ymax"}, 32'(y_max), 0);
    chk({tag, "_found"}, 32'(bbox_found), 0);
    chk({tag, "_sv"}, 32'(stats_valid), 0);
  endtask

  // Drop ce and wiggle inputs; every visible output must hold.
  task automatic stall(input int n);
    logic [7:0] m0;
    logic d0, h0, v0;
    logic [20:0] c0;
    m0 = mask_r; d0 = de_out; h0 = hsync_out; v0 = vsync_out; c0 = skin_count;
    ce = 1'b0; de_in = ~de_in; vsync_in = 1'b1; H = 8'hAB;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("stall_mask", 32'(mask_r), 32'(m0));
      chk("stall_de", 32'(de_out), 32'(d0));
      chk("stall_hs", 32'(hsync_out), 32'(h0));
      chk("stall_vs", 32'(vsync_out), 32'(v0));
      chk("stall_cnt", 32'(skin_count), 32'(c0));
      chk("stall_sv", 32'(stats_valid), 0);
    end
    ce = 1'b1;
  endtask

  // 16-pixel lines; skin only at (ax,ay) and (bx,by); optional stall after pixel (sx,sy).
  task automatic frame(input int ax, input int ay, input int bx, input int by,
                       input int sy, input int sx, input int ny);
    for (int y = 0; y < ny; y++) begin
      for (int x = 0; x < 16; x++) begin
        bit sk;
        sk = (x == ax && y == ay) || (x == bx && y == by);
        step(1'b1, 1'b0, 1'b0, sk ? 8'd10 : 8'd30, 8'd100, 8'd150);
        if (y == sy && x == sx) stall(5);
      end
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      idle(2);
    end
  endtask

  task automatic check_stats(input string tag, input int p0, input int cnt, input int x0,
                             input int x1, input int y0, input int y1, input bit found);
    chk({tag, "_pulses"}, pulses - p0, 1);
    chk({tag, "_cnt"}, cap_cnt, cnt);
    chk({tag, "_xmin"}, cap_xmin, x0);
    chk({tag, "_xmax"}, cap_xmax, x1);
    chk({tag, "_ymin"}, cap_ymin, y0);
    chk({tag, "_ymax"}, cap_ymax, y1);
    chk({tag, "_found"}, 32'(cap_found), 32'(found));
  endtask

  initial begin
    int p0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);
    check_zero("idle");

    // Latency: one skin pixel then one outside the hue window
    h_min = 8'd0; h_max = 8'd20; s_min = 8'd50; s_max = 8'd200; v_min = 8'd50; v_max = 8'd250;
    vpulse();
    step(1'b1, 1'b0, 1'b0, 8'd10, 8'd100, 8'd150);
    chk("lat_early", 32'(mask_r), 0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("lat_mask", 32'(mask_r), 32'hFF);
    chk("lat_de", 32'(de_out), 1);
    step(1'b1, 1'b0, 1'b0, 8'd30, 8'd100, 8'd150);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("h30_mask", 32'(mask_r), 0);
    chk("h30_de", 32'(de_out), 1);
    idle(2);

    // Wrapped hue window
    h_min = 8'd240; h_max = 8'd15;
    vpulse();
    step(1'b1, 1'b0, 1'b0, 8'd250, 8'd100, 8'd150);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("wrap250", 32'(mask_r), 32'hFF);
    step(1'b1, 1'b0, 1'b0, 8'd5, 8'd100, 8'd150);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("wrap5", 32'(mask_r), 32'hFF);
    step(1'b1, 1'b0, 1'b0, 8'd100, 8'd100, 8'd150);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("wrap100", 32'(mask_r), 0);
    idle(2);

    // Bounding box on a 16x8 frame
    h_min = 8'd0; h_max = 8'd20;
    vpulse();
    frame(3, 2, 10, 5, -1, -1, 8);
    p0 = pulses;
    vpulse();
    check_stats("bbox", p0, 2, 3, 10, 2, 5, 1'b1);

    // Empty frame
    frame(-1, -1, -1, -1, -1, -1, 8);
    p0 = pulses;
    vpulse();
    check_stats("empty", p0, 0, 0, 0, 0, 0, 1'b0);

    // Same bbox frame with a 5-cycle ce stall mid-line
    frame(3, 2, 10, 5, 2, 5, 8);
    p0 = pulses;
    vpulse();
    check_stats("ce", p0, 2, 3, 10, 2, 5, 1'b1);

    // Asynchronous reset in the middle of a frame
    frame(1, 1, -1, -1, -1, -1, 3);
    step(1'b1, 1'b0, 1'b0, 8'd10, 8'd100, 8'd150);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    rst_n = 1'b1;
    idle(3);
    vpulse();
    frame(0, 0, 15, 7, -1, -1, 8);
    p0 = pulses;
    vpulse();
    check_stats("corner", p0, 2, 0, 15, 0, 7, 1'b1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
